ternary_dmem_arbiter: RTL and testbench

Two-port arbiter that shares the balanced-ternary CPU's single data-memory port between the CPU load/store unit and a host/debug requester. It sits between `ternary_cpu` and the data memory array (combinational read, write on rising clk). The CPU has absolute priority and is never stalled. The host is served in CPU-idle cycles through a req/ack handshake, with range checking and starvation monitoring.

---
 rtl/ternary_dmem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_ternary_dmem_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ternary_dmem_arbiter.sv
// ternary_dmem_arbiter
//
// Shares the single data-memory port of the balanced-ternary CPU between the
// CPU load/store unit and a host/debug requester. The CPU has absolute
// priority and is never stalled. The host is served in CPU-idle cycles through
// a level req / one-cycle ack handshake.
//
// Trit encoding (one trit = 2 bits): 2'b00 = 0, 2'b01 = +1, 2'b10 = -1.
// 2'b11 is not a legal trit and decodes as 0.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cpu_addr_i            CPU data address (9 trits)
//   cpu_wdata_i           CPU store data
//   cpu_we_i, cpu_re_i    CPU store / load strobes
//   cpu_rdata_o           load data to CPU (always the memory read data)
//   host_req_i            host request, level, held until ack
//   host_we_i             host direction, 1 = write
//   host_addr_i           host address (9 trits)
//   host_wdata_i          host write data
//   host_ack_o            one-cycle completion pulse
//   host_rdata_o          captured read data, valid with ack
//   host_err_o            out-of-range flag, valid with ack
//   host_starved_o        sticky: a host wait reached HOST_MAX_WAIT cycles
//   host_grants_o         completed host accesses, wrapping 16-bit count
//   mem_addr_o            address to memory
//   mem_wdata_o           write data to memory
//   mem_we_o              memory write enable
//   mem_rdata_i           memory read data (combinational)

module ternary_dmem_arbiter #(
  parameter int unsigned TRIT_WIDTH    = 27,
  parameter int unsigned DMEM_DEPTH    = 729,
  parameter int unsigned HOST_MAX_WAIT = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  // CPU side
  input  logic [8:0][1:0]             cpu_addr_i,
  input  logic [TRIT_WIDTH-1:0][1:0]  cpu_wdata_i,
  input  logic                        cpu_we_i,
  input  logic                        cpu_re_i,
  output logic [TRIT_WIDTH-1:0][1:0]  cpu_rdata_o,
  // Host side
  input  logic                        host_req_i,
  input  logic                        host_we_i,
  input  logic [8:0][1:0]             host_addr_i,
  input  logic [TRIT_WIDTH-1:0][1:0]  host_wdata_i,
  output logic                        host_ack_o,
  output logic [TRIT_WIDTH-1:0][1:0]  host_rdata_o,
  output logic                        host_err_o,
  output logic                        host_starved_o,
  output logic [15:0]                 host_grants_o,
  // Memory side
  output logic [8:0][1:0]             mem_addr_o,
  output logic [TRIT_WIDTH-1:0][1:0]  mem_wdata_o,
  output logic                        mem_we_o,
  input  logic [TRIT_WIDTH-1:0][1:0]  mem_rdata_i
);

  localparam int unsigned WaitW = $clog2(HOST_MAX_WAIT + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StAck  = 2'd2;

  logic [1:0]                       state_q, state_d;
  logic [WaitW-1:0]                 wait_cnt_q, wait_cnt_d;
  logic                             starved_q, starved_d;
  logic                             ack_q, ack_d;
  logic                             err_q, err_d;
  logic [TRIT_WIDTH-1:0][1:0]       rdata_q, rdata_d;
  logic [15:0]                      grants_q, grants_d;

  logic                             cpu_busy;
  logic                             grant;
  logic                             in_range;
  logic signed [15:0]               host_addr_val;

  function automatic logic signed [15:0] trit_val(input logic [1:0] t);
    case (t)
      2'b01:   return 16'sd1;
      2'b10:   return -16'sd1;
      default: return 16'sd0;
    endcase
  endfunction

  // Horner evaluation of the 9-trit address; range is +/-9841, fits 16 bits.
  always_comb begin
    host_addr_val = '0;
    for (int i = 8; i >= 0; i--) begin
      host_addr_val = host_addr_val * 16'sd3 + trit_val(host_addr_i[i]);
    end
  end

  assign in_range = !host_addr_val[15] && ({16'd0, host_addr_val} < DMEM_DEPTH);

  assign cpu_busy = cpu_re_i | cpu_we_i;
  // No grant in the ack cycle, which caps the host at one access per 2 cycles.
  assign grant    = host_req_i & ~cpu_busy & (state_q != StAck);

  assign mem_addr_o  = grant ? host_addr_i  : cpu_addr_i;
  assign mem_wdata_o = grant ? host_wdata_i : cpu_wdata_i;
  assign mem_we_o    = cpu_we_i | (grant & host_we_i & in_range);
  assign cpu_rdata_o = mem_rdata_i;

  // Next-state for the handshake FSM and the starvation monitor.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    starved_d  = starved_q;
    case (state_q)
      StIdle: begin
        if (grant) begin
          state_d = StAck;
        end else if (host_req_i && cpu_busy) begin
          state_d    = StWait;
          wait_cnt_d = '0;
        end
      end
      StWait: begin
        // Every cycle spent here counts, including the one that is granted.
        if (wait_cnt_q != WaitW'(HOST_MAX_WAIT)) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
        if (wait_cnt_d == WaitW'(HOST_MAX_WAIT)) begin
          starved_d = 1'b1;
        end
        if (grant) begin
          state_d = StAck;
        end else if (!host_req_i) begin
          state_d = StIdle;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Completion capture happens on the edge that ends the grant cycle.
  always_comb begin
    ack_d    = grant;
    err_d    = err_q;
    rdata_d  = rdata_q;
    grants_d = grants_q;
    if (grant) begin
      err_d    = ~in_range;
      rdata_d  = (!host_we_i && in_range) ? mem_rdata_i : '0;
      grants_d = grants_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      starved_q  <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      grants_q   <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      starved_q  <= starved_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      grants_q   <= grants_d;
    end
  end

  assign host_ack_o     = ack_q;
  assign host_err_o     = err_q;
  assign host_rdata_o   = rdata_q;
  assign host_starved_o = starved_q;
  assign host_grants_o  = grants_q;

endmodule

// File: tb/tb_ternary_dmem_arbiter.sv
// Bench for ternary_dmem_arbiter: table of host transactions from idle,
// hand-written contention / starvation / reset sequences, then randomized
// traffic checked against an integer-valued reference memory.

module tb_ternary_dmem_arbiter;

  localparam int unsigned TW    = 27;
  localparam int unsigned DEPTH = 729;
  localparam int unsigned MAXW  = 16;

  typedef logic [TW-1:0][1:0] word_t;
  typedef logic [8:0][1:0]    addr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  addr_t       cpu_addr;
  word_t       cpu_wdata;
  logic        cpu_we, cpu_re;
  word_t       cpu_rdata;
  logic        host_req, host_we;
  addr_t       host_addr;
  word_t       host_wdata;
  logic        host_ack;
  word_t       host_rdata;
  logic        host_err, host_starved;
  logic [15:0] host_grants;
  addr_t       mem_addr;
  word_t       mem_wdata;
  logic        mem_we;
  word_t       mem_rdata;

  always #5 clk = ~clk;

  ternary_dmem_arbiter #(
    .TRIT_WIDTH   (TW),
    .DMEM_DEPTH   (DEPTH),
    .HOST_MAX_WAIT(MAXW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_addr_i    (cpu_addr),
    .cpu_wdata_i   (cpu_wdata),
    .cpu_we_i      (cpu_we),
    .cpu_re_i      (cpu_re),
    .cpu_rdata_o   (cpu_rdata),
    .host_req_i    (host_req),
    .host_we_i     (host_we),
    .host_addr_i   (host_addr),
    .host_wdata_i  (host_wdata),
    .host_ack_o    (host_ack),
    .host_rdata_o  (host_rdata),
    .host_err_o    (host_err),
    .host_starved_o(host_starved),
    .host_grants_o (host_grants),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_we_o      (mem_we),
    .mem_rdata_i   (mem_rdata)
  );

  // ---------------- balanced-ternary helpers ----------------
  function automatic word_t enc(input longint v);
    word_t  w = '0;
    longint x = v;
    longint r;
    for (int i = 0; i < int'(TW); i++) begin
      r = x % 3;
      if (r < 0) r += 3;
      if (r == 1) begin
        w[i] = 2'b01;
        x = x - 1;
      end else if (r == 2) begin
        w[i] = 2'b10;
        x = x + 1;
      end else begin
        w[i] = 2'b00;
      end
      x = x / 3;
    end
    return w;
  endfunction

  function automatic addr_t enc_addr(input int v);
    word_t w;
    w = enc(longint'(v));
    return w[8:0];
  endfunction

  function automatic longint dec(input word_t w);
    longint v = 0;
    for (int i = int'(TW) - 1; i >= 0; i--) begin
      v = v * 3;
      if (w[i] == 2'b01) v = v + 1;
      else if (w[i] == 2'b10) v = v - 1;
    end
    return v;
  endfunction

  function automatic int dec_addr(input addr_t a);
    word_t w = '0;
    w[8:0] = a;
    return int'(dec(w));
  endfunction

  // ---------------- data memory attached to the DUT ----------------
  bit [TW-1:0][1:0] tb_mem [DEPTH];
  int               mem_idx;

  always_comb begin
    mem_idx   = dec_addr(mem_addr);
    mem_rdata = '0;
    if (mem_idx >= 0 && mem_idx < int'(DEPTH)) mem_rdata = tb_mem[mem_idx];
  end

  always @(posedge clk) begin
    if (mem_we && mem_idx >= 0 && mem_idx < int'(DEPTH)) tb_mem[mem_idx] <= mem_wdata;
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int exp_grants = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_set(input bit re, input bit we, input int addr, input longint wdata);
    cpu_re    = re;
    cpu_we    = we;
    cpu_addr  = enc_addr(addr);
    cpu_wdata = enc(wdata);
  endtask

  task automatic host_set(input bit req, input bit we, input int addr, input longint wdata);
    host_req   = req;
    host_we    = we;
    host_addr  = enc_addr(addr);
    host_wdata = enc(wdata);
  endtask

  // ---------------- transaction table ----------------
  typedef struct {
    int     addr;
    bit     we;
    longint wdata;
    bit     exp_err;
    longint exp_rdata;
    bit     exp_mem_we;
  } vec_t;

  vec_t vecs[13];

  // Reference memory for the random phase (region 200..263 only).
  longint ref_mem [DEPTH];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cpu_set(0, 0, 0, 0);
    host_set(0, 0, 0, 0);
    #2;
    chk("rst_ack", longint'(host_ack), 0);
    chk("rst_err", longint'(host_err), 0);
    chk("rst_starved", longint'(host_starved), 0);
    chk("rst_grants", longint'(host_grants), 0);
    chk("rst_rdata_bits", longint'(host_rdata), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // addr, we, wdata, exp_err, exp_rdata, exp_mem_we
    vecs[0]  = '{addr: 5,     we: 1, wdata: 42,    exp_err: 0, exp_rdata: 0,     exp_mem_we: 1};
    vecs[1]  = '{addr: 5,     we: 0, wdata: 0,     exp_err: 0, exp_rdata: 42,    exp_mem_we: 0};
    vecs[2]  = '{addr: -1,    we: 0, wdata: 0,     exp_err: 1, exp_rdata: 0,     exp_mem_we: 0};
    vecs[3]  = '{addr: 729,   we: 1, wdata: 77,    exp_err: 1, exp_rdata: 0,     exp_mem_we: 0};
    vecs[4]  = '{addr: 728,   we: 1, wdata: -1000, exp_err: 0, exp_rdata: 0,     exp_mem_we: 1};
    vecs[5]  = '{addr: 728,   we: 0, wdata: 0,     exp_err: 0, exp_rdata: -1000, exp_mem_we: 0};
    vecs[6]  = '{addr: 0,     we: 1, wdata: 13,    exp_err: 0, exp_rdata: 0,     exp_mem_we: 1};
    vecs[7]  = '{addr: 0,     we: 0, wdata: 0,     exp_err: 0, exp_rdata: 13,    exp_mem_we: 0};
    vecs[8]  = '{addr: 729,   we: 0, wdata: 0,     exp_err: 1, exp_rdata: 0,     exp_mem_we: 0};
    vecs[9]  = '{addr: -9841, we: 0, wdata: 0,     exp_err: 1, exp_rdata: 0,     exp_mem_we: 0};
    vecs[10] = '{addr: 9841,  we: 1, wdata: 5,     exp_err: 1, exp_rdata: 0,     exp_mem_we: 0};
    vecs[11] = '{addr: 6,     we: 0, wdata: 0,     exp_err: 0, exp_rdata: 0,     exp_mem_we: 0};
    vecs[12] = '{addr: 728,   we: 0, wdata: 0,     exp_err: 0, exp_rdata: -1000, exp_mem_we: 0};

    for (int i = 0; i < 13; i++) begin
      host_set(1, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      #1;
      chk($sformatf("tbl%0d_mem_we", i), longint'(mem_we), longint'(vecs[i].exp_mem_we));
      chk($sformatf("tbl%0d_mem_addr", i), longint'(dec_addr(mem_addr)), longint'(vecs[i].addr));
      tick();
      exp_grants++;
      chk($sformatf("tbl%0d_ack", i), longint'(host_ack), 1);
      chk($sformatf("tbl%0d_err", i), longint'(host_err), longint'(vecs[i].exp_err));
      chk($sformatf("tbl%0d_rdata", i), dec(host_rdata), vecs[i].exp_rdata);
      chk($sformatf("tbl%0d_grants", i), longint'(host_grants), longint'(exp_grants));
      host_set(0, 0, 0, 0);
      tick();
      chk($sformatf("tbl%0d_ack_low", i), longint'(host_ack), 0);
    end

    // Contention: CPU loads for 4 cycles, host read of addr 0 waits.
    cpu_set(1, 0, 5, 0);
    host_set(1, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("cont_mem_addr", longint'(dec_addr(mem_addr)), 5);
      chk("cont_cpu_rdata", dec(cpu_rdata), 42);
      chk("cont_mem_we", longint'(mem_we), 0);
      tick();
      chk("cont_no_ack", longint'(host_ack), 0);
    end
    cpu_set(0, 0, 5, 0);
    #1;
    chk("cont_grant_addr", longint'(dec_addr(mem_addr)), 0);
    tick();
    exp_grants++;
    chk("cont_ack", longint'(host_ack), 1);
    chk("cont_rdata", dec(host_rdata), 13);
    host_set(0, 0, 0, 0);
    tick();

    // Simultaneous write to addr 7: CPU 9 first, then host 3.
    cpu_set(0, 1, 7, 9);
    host_set(1, 1, 7, 3);
    #1;
    chk("sim_mem_we", longint'(mem_we), 1);
    chk("sim_cpu_wdata", dec(mem_wdata), 9);
    tick();
    chk("sim_no_ack", longint'(host_ack), 0);
    cpu_set(0, 0, 7, 0);
    #1;
    chk("sim_cpu_wrote", dec(cpu_rdata), 9);
    chk("sim_host_wdata", dec(mem_wdata), 3);
    chk("sim_host_we", longint'(mem_we), 1);
    tick();
    exp_grants++;
    chk("sim_ack", longint'(host_ack), 1);
    host_set(0, 0, 0, 0);
    tick();
    cpu_set(1, 0, 7, 0);
    #1;
    chk("sim_final_mem7", dec(cpu_rdata), 3);
    tick();
    cpu_set(0, 0, 0, 0);

    // Back-to-back: req held through the ack cycle is not granted there.
    host_set(1, 0, 5, 0);
    tick();
    exp_grants++;
    chk("b2b_ack1", longint'(host_ack), 1);
    chk("b2b_rdata1", dec(host_rdata), 42);
    tick();
    chk("b2b_gap", longint'(host_ack), 0);
    tick();
    exp_grants++;
    chk("b2b_ack2", longint'(host_ack), 1);
    chk("b2b_grants", longint'(host_grants), longint'(exp_grants));
    host_set(0, 0, 0, 0);
    tick();

    // Abandoned write while waiting: no access, no ack.
    cpu_set(1, 0, 0, 0);
    host_set(1, 1, 5, 999);
    tick();
    host_set(0, 1, 5, 999);
    cpu_set(0, 0, 0, 0);
    #1;
    chk("abn_mem_we", longint'(mem_we), 0);
    tick();
    chk("abn_no_ack1", longint'(host_ack), 0);
    tick();
    chk("abn_no_ack2", longint'(host_ack), 0);
    chk("abn_grants", longint'(host_grants), longint'(exp_grants));
    host_set(1, 0, 5, 0);
    tick();
    exp_grants++;
    chk("abn_mem5_kept", dec(host_rdata), 42);
    host_set(0, 0, 0, 0);
    tick();

    // Starvation: CPU busy 20 cycles with a pending host read.
    cpu_set(1, 0, 5, 0);
    host_set(1, 0, 5, 0);
    for (int e = 1; e <= 20; e++) begin
      tick();
      chk("stv_no_ack", longint'(host_ack), 0);
      if (e == 16) chk("stv_not_yet", longint'(host_starved), 0);
      if (e == 17) chk("stv_set", longint'(host_starved), 1);
    end
    cpu_set(0, 0, 5, 0);
    tick();
    exp_grants++;
    chk("stv_ack", longint'(host_ack), 1);
    chk("stv_rdata", dec(host_rdata), 42);
    chk("stv_sticky1", longint'(host_starved), 1);
    host_set(0, 0, 0, 0);
    tick();
    tick();
    chk("stv_sticky2", longint'(host_starved), 1);

    // Reset while waiting: registers clear at once, no ack, then service resumes.
    cpu_set(1, 0, 5, 0);
    host_set(1, 0, 0, 0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rw_ack", longint'(host_ack), 0);
    chk("rw_starved", longint'(host_starved), 0);
    chk("rw_grants", longint'(host_grants), 0);
    chk("rw_rdata_bits", longint'(host_rdata), 0);
    chk("rw_err", longint'(host_err), 0);
    #1;
    rst_n = 1'b1;
    cpu_set(0, 0, 0, 0);
    #1;
    tick();
    exp_grants = 1;
    chk("rw_resume_ack", longint'(host_ack), 1);
    chk("rw_resume_rdata", dec(host_rdata), 13);
    chk("rw_resume_grants", longint'(host_grants), 1);
    host_set(0, 0, 0, 0);
    tick();

    // Randomized traffic against an integer reference memory.
    begin
      bit     pend = 0;
      bit     p_we = 0;
      int     p_addr = 0;
      longint p_wdata = 0;
      bit     exp_ack = 0;
      bit     exp_err_r = 0;
      longint exp_rd = 0;
      int     busy_run = 0;
      bit     c_re, c_we, served, in_rng;
      int     c_addr, k, r;
      longint c_wdata;
      for (int cyc = 0; cyc < 400; cyc++) begin
        if (exp_ack) pend = 0;
        else if (pend && $urandom_range(15) == 0) pend = 0;
        if (!pend && $urandom_range(1) == 1) begin
          pend    = 1;
          p_we    = 1'($urandom_range(1));
          r       = int'($urandom_range(9));
          if (r == 0) p_addr = -1 - int'($urandom_range(4));
          else if (r == 1) p_addr = 729 + int'($urandom_range(10));
          else p_addr = 200 + int'($urandom_range(63));
          p_wdata = longint'($urandom_range(2000000)) - 1000000;
        end
        k        = (busy_run >= 8) ? 0 : int'($urandom_range(4));
        c_re     = (k == 1) || (k == 2);
        c_we     = (k == 3);
        busy_run = (c_re || c_we) ? busy_run + 1 : 0;
        c_addr   = 200 + int'($urandom_range(63));
        c_wdata  = longint'($urandom_range(2000000)) - 1000000;
        cpu_set(c_re, c_we, c_addr, c_wdata);
        host_set(pend, p_we, p_addr, p_wdata);

        // Host is served when the CPU is idle and this is not an ack cycle.
        served = pend && !(c_re || c_we) && !exp_ack;
        in_rng = (p_addr >= 0) && (p_addr < int'(DEPTH));
        #1;
        chk("rnd_mem_we", longint'(mem_we), longint'(c_we || (served && p_we && in_rng)));
        if (c_re) chk("rnd_cpu_rdata", dec(cpu_rdata), ref_mem[c_addr]);
        if (served) begin
          exp_rd    = (!p_we && in_rng) ? ref_mem[p_addr] : 0;
          exp_err_r = !in_rng;
          exp_grants++;
        end
        if (c_we) ref_mem[c_addr] = c_wdata;
        if (served && p_we && in_rng) ref_mem[p_addr] = p_wdata;
        exp_ack = served;
        tick();
        chk("rnd_ack", longint'(host_ack), longint'(exp_ack));
        if (exp_ack) begin
          chk("rnd_rdata", dec(host_rdata), exp_rd);
          chk("rnd_err", longint'(host_err), longint'(exp_err_r));
        end
        chk("rnd_grants", longint'(host_grants), longint'(exp_grants));
        chk("rnd_starved", longint'(host_starved), 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
